// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the instruction queue between fetch and decode.
// Stands in for the bus widths and flag encodings of the common CPU define set.
package inst_queue_pkg;

    localparam int INST_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int IQ_DEPTH = 16;

    localparam logic IQ_EMPTY  = 1'b1;
    localparam logic IQ_ENABLE = 1'b1;
    localparam logic IQ_VALID  = 1'b1;

    typedef logic [INST_W-1:0] inst_bus_t;
    typedef logic [ADDR_W-1:0] addr_bus_t;

    typedef struct packed {
        inst_bus_t inst;
        addr_bus_t pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push, decode-side pop and flush signals of the instruction queue.
// The slave modport is the queue itself; master is the surrounding pipeline.
interface inst_queue_if;
    import inst_queue_pkg::*;

    logic      IF_valid;
    inst_bus_t IF_inst;
    addr_bus_t IF_pc;
    logic      IF_queue_is_full;

    logic      ROB_clear;

    logic      InstQueue_enable;
    logic      InstQueue_queue_is_empty;
    inst_bus_t InstQueue_inst;
    addr_bus_t InstQueue_pc;

    modport master (
        output IF_valid,
        output IF_inst,
        output IF_pc,
        input  IF_queue_is_full,
        output ROB_clear,
        output InstQueue_enable,
        input  InstQueue_queue_is_empty,
        input  InstQueue_inst,
        input  InstQueue_pc
    );

    modport slave (
        input  IF_valid,
        input  IF_inst,
        input  IF_pc,
        output IF_queue_is_full,
        input  ROB_clear,
        input  InstQueue_enable,
        output InstQueue_queue_is_empty,
        output InstQueue_inst,
        output InstQueue_pc
    );

endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode with flush and global stall.
// Define INST_QUEUE_BYPASS_EN to let a push into an empty queue be seen at the head in the same cycle.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    inst_queue_if.slave iq
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    iq_entry_t mem_q [DEPTH];
    iq_entry_t wr_entry;
    logic      wr_en;

    logic stored_empty;
    logic full;
    logic bypass;
    logic push_ok;
    logic pop_ok;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        wr_entry = '{inst: iq.IF_inst, pc: iq.IF_pc};

        stored_empty = (count_q == '0);
        full         = (count_q == FULL_CNT);

`ifdef INST_QUEUE_BYPASS_EN
        bypass = stored_empty && (iq.IF_valid == IQ_VALID) && !iq.ROB_clear;
`else
        bypass = 1'b0;
`endif

        push_ok = (iq.IF_valid == IQ_VALID) && rdy && !full;
        pop_ok  = (iq.InstQueue_enable == IQ_ENABLE) && rdy && (!stored_empty || bypass);

        if (rdy) begin
            if (iq.ROB_clear) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else if (!(bypass && pop_ok)) begin
                // A bypassed word popped in the same cycle never touches storage.
                if (push_ok) begin
                    wr_en  = 1'b1;
                    tail_d = tail_q + PTR_ONE;
                end
                if (pop_ok) begin
                    head_d = head_q + PTR_ONE;
                end
                unique case ({push_ok, pop_ok})
                    2'b10:   count_d = count_q + CNT_ONE;
                    2'b01:   count_d = count_q - CNT_ONE;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_comb begin
        iq.IF_queue_is_full         = full;
        iq.InstQueue_queue_is_empty = (stored_empty && !bypass) ? IQ_EMPTY : ~IQ_EMPTY;
        if (bypass) begin
            iq.InstQueue_inst = iq.IF_inst;
            iq.InstQueue_pc   = iq.IF_pc;
        end else if (!stored_empty) begin
            iq.InstQueue_inst = mem_q[head_q].inst;
            iq.InstQueue_pc   = mem_q[head_q].pc;
        end else begin
            iq.InstQueue_inst = '0;
            iq.InstQueue_pc   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; outputs are forced to zero while empty, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[tail_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized traffic
// against a queue-based reference model of the push/pop/flush/stall rules.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 16;
`ifdef INST_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    always #5 clk = ~clk;

    inst_queue_if iq_bus ();

    inst_queue #(.DEPTH(DEPTH), .PTR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .iq  (iq_bus)
    );

    logic [63:0] mq [$];
    int n_total = 0;
    int n_pass  = 0;

    function automatic logic [65:0] exp_vec();
        bit          byp;
        logic [63:0] head;
        byp = BYP && (mq.size() == 0) && iq_bus.IF_valid && !iq_bus.ROB_clear;
        if (byp)              head = {iq_bus.IF_inst, iq_bus.IF_pc};
        else if (mq.size() > 0) head = mq[0];
        else                  head = 64'h0;
        return {(mq.size() == DEPTH), ((mq.size() == 0 && !byp) ? IQ_EMPTY : ~IQ_EMPTY), head};
    endfunction

    function automatic logic [65:0] obs_vec();
        return {iq_bus.IF_queue_is_full, iq_bus.InstQueue_queue_is_empty,
                iq_bus.InstQueue_inst, iq_bus.InstQueue_pc};
    endfunction

    task automatic model_step();
        bit byp, push, pop;
        if (rst) begin
            mq.delete();
        end else if (rdy) begin
            if (iq_bus.ROB_clear) begin
                mq.delete();
            end else begin
                byp  = BYP && (mq.size() == 0) && iq_bus.IF_valid;
                push = iq_bus.IF_valid && (mq.size() < DEPTH);
                pop  = iq_bus.InstQueue_enable && (mq.size() > 0 || byp);
                if (!(byp && pop)) begin
                    if (pop)  void'(mq.pop_front());
                    if (push) mq.push_back({iq_bus.IF_inst, iq_bus.IF_pc});
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic en, input logic clr, input logic r);
        iq_bus.IF_valid         = v;
        iq_bus.IF_inst          = inst;
        iq_bus.IF_pc            = pc;
        iq_bus.InstQueue_enable = en;
        iq_bus.ROB_clear        = clr;
        rdy                     = r;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        logic [65:0] o;
        rst = 1'b1;
        drive(1, $urandom, $urandom, 1, 0, 0);
        tick();
        drive(1, $urandom, $urandom, 1, 0, 1);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        o = obs_vec();
        n_total++;
        if (o !== {1'b0, IQ_EMPTY, 64'h0})
            $display("FAIL reset_state got=%h want=%h", o, {1'b0, IQ_EMPTY, 64'h0});
        else n_pass++;
    endtask

    task automatic test_single_push();
        logic [65:0] o, e;
        do_reset();
        drive(1, 32'h0000_0013, 32'h0, 0, 0, 1);
        o = obs_vec(); e = exp_vec();
        n_total++;
        if (o !== e) $display("FAIL push_same_cycle got=%h want=%h", o, e);
        else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 1);
        o = obs_vec();
        n_total++;
        if (o !== {1'b0, ~IQ_EMPTY, 32'h0000_0013, 32'h0})
            $display("FAIL push_next_cycle got=%h want=%h", o, {1'b0, ~IQ_EMPTY, 32'h0000_0013, 32'h0});
        else n_pass++;
    endtask

    task automatic fill16();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, $urandom, 32'(i * 4), 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_fill();
        logic [65:0] o, e;
        fill16();
        n_total++;
        if (iq_bus.IF_queue_is_full !== 1'b1)
            $display("FAIL full_after_16 got=%b want=1", iq_bus.IF_queue_is_full);
        else n_pass++;
        drive(1, 32'hFFFF_FFFF, 32'h0000_0FF0, 0, 0, 1);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 1, 0, 1);
            o = obs_vec(); e = exp_vec();
            n_total++;
            if (o !== e || iq_bus.InstQueue_pc !== 32'(i * 4))
                $display("FAIL fill_pop_%0d got=%h want=%h pc_want=%h", i, o, e, 32'(i * 4));
            else n_pass++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        n_total++;
        if (iq_bus.InstQueue_queue_is_empty !== IQ_EMPTY)
            $display("FAIL drained_empty got=%b want=%b", iq_bus.InstQueue_queue_is_empty, IQ_EMPTY);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        int pops;
        fill16();
        drive(1, 32'hDEAD_BEEF, 32'h0000_FFF0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_total++;
        if (iq_bus.IF_queue_is_full !== 1'b0)
            $display("FAIL full_pushpop_full got=%b want=0", iq_bus.IF_queue_is_full);
        else n_pass++;
        pops = 0;
        for (int k = 0; k < DEPTH + 4; k++) begin
            if (iq_bus.InstQueue_queue_is_empty === IQ_EMPTY) break;
            n_total++;
            if (iq_bus.InstQueue_pc !== 32'((k + 1) * 4))
                $display("FAIL full_pushpop_pc_%0d got=%h want=%h", k, iq_bus.InstQueue_pc, 32'((k + 1) * 4));
            else n_pass++;
            drive(0, 0, 0, 1, 0, 1);
            tick();
            drive(0, 0, 0, 0, 0, 1);
            pops++;
        end
        n_total++;
        if (pops != 15) $display("FAIL full_pushpop_count got=%0d want=15", pops);
        else n_pass++;
    endtask

    task automatic test_clear();
        logic [65:0] o;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, $urandom, 32'h40 + 32'(i), 0, 0, 1);
            tick();
        end
        drive(1, 32'h1234_5678, 32'h9999, 1, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        o = obs_vec();
        n_total++;
        if (o !== {1'b0, IQ_EMPTY, 64'h0})
            $display("FAIL clear_state got=%h want=%h", o, {1'b0, IQ_EMPTY, 64'h0});
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'hAAAA_0000 + 32'(i), 32'h100 + 32'(i * 4), 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        o = obs_vec();
        n_total++;
        if (o !== {1'b1, ~IQ_EMPTY, 32'hAAAA_0000, 32'h100})
            $display("FAIL clear_refill got=%h want=%h", o, {1'b1, ~IQ_EMPTY, 32'hAAAA_0000, 32'h100});
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [65:0] held, o, e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, $urandom, 32'h200 + 32'(i * 4), 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        held = exp_vec();
        for (int c = 0; c < 3; c++) begin
            drive(1, $urandom, $urandom, 1, 1'(c == 1), 0);
            tick();
            drive(0, 0, 0, 0, 0, 0);
            o = obs_vec();
            n_total++;
            if (o !== held) $display("FAIL stall_hold_%0d got=%h want=%h", c, o, held);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 1);
            o = obs_vec(); e = exp_vec();
            n_total++;
            if (o !== e) $display("FAIL stall_resume_%0d got=%h want=%h", i, o, e);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        logic [65:0] o, e;
        int errs;
        do_reset();
        errs = 0;
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 9) < 6), $urandom, $urandom,
                  1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 99) < 3),
                  1'($urandom_range(0, 9) < 8));
            o = obs_vec(); e = exp_vec();
            n_total++;
            if (o !== e) begin
                if (errs < 10) $display("FAIL random_cycle_%0d got=%h want=%h", c, o, e);
                errs++;
            end else n_pass++;
            tick();
        end
    endtask

`ifdef INST_QUEUE_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        drive(1, 32'h0010_0093, 32'h0000_0300, 1, 0, 1);
        n_total++;
        if (iq_bus.InstQueue_inst !== 32'h0010_0093 || iq_bus.InstQueue_queue_is_empty !== ~IQ_EMPTY)
            $display("FAIL bypass_same_cycle got=%h/%b want=00100093/%b",
                     iq_bus.InstQueue_inst, iq_bus.InstQueue_queue_is_empty, ~IQ_EMPTY);
        else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_total++;
        if (iq_bus.InstQueue_queue_is_empty !== IQ_EMPTY)
            $display("FAIL bypass_after got=%b want=%b", iq_bus.InstQueue_queue_is_empty, IQ_EMPTY);
        else n_pass++;
        drive(1, 32'h0010_0093, 32'h0000_0300, 1, 1, 1);
        n_total++;
        if (iq_bus.InstQueue_queue_is_empty !== IQ_EMPTY)
            $display("FAIL bypass_clear got=%b want=%b", iq_bus.InstQueue_queue_is_empty, IQ_EMPTY);
        else n_pass++;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        test_reset();
        test_single_push();
        test_fill();
        test_full_push_pop();
        test_clear();
        test_stall();
`ifdef INST_QUEUE_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries (power of two, >=4).
REQ-002 SHALL have parameter PTR_W, default 4, log2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rdy  input  1  global ready; low freezes all state.
REQ-006 SHALL have port IF_valid  input  1  fetch pushes an instruction this cycle.
REQ-007 SHALL have port IF_inst  input  32  fetched instruction word.
REQ-008 SHALL have port IF_pc  input  32  PC of fetched instruction.
REQ-009 SHALL have port IF_queue_is_full  output  1  high = no free entry; fetch must not push.
REQ-010 SHALL have port ROB_clear  input  1  misprediction flush.
REQ-011 SHALL have port InstQueue_enable  input  1  decode pops the head this cycle.
REQ-012 SHALL have port InstQueue_queue_is_empty  output  1  equals `IQEmpty when no head is presentable.
REQ-013 SHALL have port InstQueue_inst  output  32  head instruction.
REQ-014 SHALL have port InstQueue_pc  output  32  head PC.

Function
REQ-015 SHALL store entries {inst, pc} in a circular buffer addressed by head and tail pointers of PTR_W bits, plus a count register of PTR_W+1 bits.
REQ-016 SHALL accept a push when IF_valid=1, rdy=1, count<DEPTH: write at tail, tail+1 mod DEPTH.
REQ-017 SHALL ignore a push when count==DEPTH, even if a pop occurs in the same cycle.
REQ-018 SHALL perform a pop when InstQueue_enable=1, rdy=1, count>0: head+1 mod DEPTH.
REQ-019 SHALL update count as +1 for push only, -1 for pop only, and unchanged for simultaneous push and pop.
REQ-020 SHALL drive IF_queue_is_full combinationally as (count==DEPTH).
REQ-021 SHALL drive InstQueue_queue_is_empty combinationally from count==0, with outputs of mem[head] when non-empty.
REQ-022 SHALL ignore a pop while empty, leaving no state change.
REQ-023 SHALL give ROB_clear=1 (with rdy=1) priority over push and pop: head=tail=count=0 next cycle; same-cycle push discarded.
REQ-024 SHALL, when rdy=0, hold all registers unchanged, rst excepted.
REQ-025 SHALL make a pushed entry visible at head no earlier than the cycle after the push (baseline latency 1).

Reset
REQ-026 SHALL, on rst=1 at a clock edge, clear head, tail and count to 0, regardless of rdy or any in-flight push/pop.
REQ-027 SHALL, after reset, drive IF_queue_is_full=0, InstQueue_queue_is_empty=`IQEmpty, and InstQueue_inst/InstQueue_pc=0.

Configuration
REQ-028 SHALL, with INST_QUEUE_BYPASS_EN defined: when count==0 and IF_valid=1, present IF_inst/IF_pc on the head outputs and deassert empty in the same cycle; a same-cycle pop consumes it without writing storage.
REQ-029 SHALL, without INST_QUEUE_BYPASS_EN, behave exactly per REQ-025 (no bypass path).
REQ-030 SHALL disable bypass on cycles with ROB_clear=1 in either configuration.

Structure
REQ-031 SHALL take InstBus, AddressBus, `IQEmpty, `Enable and `Valid from the shared cpu_define.v; DEPTH default added there as IQ_DEPTH.
REQ-032 SHALL be a single module with no sub-module; storage as register arrays.

Verification
REQ-033 SHALL cover: reset, then push 0x00000013@pc 0x0 -> next cycle empty deasserted, inst=0x00000013, pc=0x0.
REQ-034 SHALL cover: 16 consecutive pushes, no pops -> full=1 after 16th; 17th push ignored; pops return pcs 0x0..0x3C in order.
REQ-035 SHALL cover: full queue with simultaneous push+pop -> count stays 16 minus 1 pop = 15; pushed word not stored.
REQ-036 SHALL cover: 5 entries stored, ROB_clear=1 with IF_valid=1 -> next cycle empty=`IQEmpty, full=0; following push lands at index 0.
REQ-037 SHALL cover: rdy=0 for 3 cycles with push/pop asserted -> count, head and outputs unchanged.
REQ-038 SHALL cover: with INST_QUEUE_BYPASS_EN, empty queue with push 0x00100093 and pop same cycle -> outputs show 0x00100093 that cycle; next cycle queue still empty.
